dmem_master: RTL and testbench

DMEM_MASTER -- requirements
Module: dmem_master

---
 rtl/dmem_master_if.sv | 41 ++++
 rtl/dmem_master.sv | 155 +++++++++++++++
 tb/tb_dmem_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_master_if.sv
// Bus bundle between the CPU-side load/store port, the data RAM port and dmem_master.
// The master modport is the dmem_master's view; slave is the CPU/RAM side.
interface dmem_master_if;
    // CPU request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    // CPU response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    // Data RAM port
    logic [63:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_data_in;
    logic [63:0] mem_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_address, mem_read_en, mem_write_en, mem_data_in,
        input  mem_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_address, mem_read_en, mem_write_en, mem_data_in,
        output mem_out
    );
endinterface

// File: rtl/dmem_master.sv
// dmem_master: turns single CPU load/store requests into data RAM accesses.
// One transaction in flight at a time; every output comes straight from a flop.
// Next values for all registers are computed together in one combinational
// process so each output is registered alongside the state it belongs to.
module dmem_master #(
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_master_if.master       bus,
    output logic [15:0]         txn_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [63:0] DEPTH_W = 64'(DEPTH);
    localparam logic [1:0]  LAST_RD = 2'(READ_LATENCY - 1);

    state_t      state, state_next;
    logic [1:0]  rd_cnt, rd_cnt_next;

    logic        req_ready_q, req_ready_next;
    logic        resp_valid_q, resp_valid_next;
    logic        resp_err_q, resp_err_next;
    logic [63:0] resp_rdata_q, resp_rdata_next;
    logic [63:0] mem_address_q, mem_address_next;
    logic [63:0] mem_data_in_q, mem_data_in_next;
    logic        mem_read_en_q, mem_read_en_next;
    logic        mem_write_en_q, mem_write_en_next;
    logic [15:0] txn_count_q, txn_count_next;

    logic        handshake;

    assign handshake = (state == IDLE) && req_ready_q && bus.req_valid;

    // State and output registers; reset drops enables and any pending response at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rd_cnt         <= 2'd0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= 64'd0;
            mem_address_q  <= 64'd0;
            mem_data_in_q  <= 64'd0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            txn_count_q    <= 16'd0;
        end else begin
            state          <= state_next;
            rd_cnt         <= rd_cnt_next;
            req_ready_q    <= req_ready_next;
            resp_valid_q   <= resp_valid_next;
            resp_err_q     <= resp_err_next;
            resp_rdata_q   <= resp_rdata_next;
            mem_address_q  <= mem_address_next;
            mem_data_in_q  <= mem_data_in_next;
            mem_read_en_q  <= mem_read_en_next;
            mem_write_en_q <= mem_write_en_next;
            txn_count_q    <= txn_count_next;
        end
    end

    // Next state and next register values; enables default low so they only pulse in RD_WAIT/WR
    always_comb begin
        state_next        = state;
        rd_cnt_next       = rd_cnt;
        req_ready_next    = req_ready_q;
        resp_valid_next   = resp_valid_q;
        resp_err_next     = resp_err_q;
        resp_rdata_next   = resp_rdata_q;
        mem_address_next  = mem_address_q;
        mem_data_in_next  = mem_data_in_q;
        mem_read_en_next  = 1'b0;
        mem_write_en_next = 1'b0;
        txn_count_next    = txn_count_q;

        case (state)
            IDLE: begin
                req_ready_next = 1'b1;
                if (handshake) begin
                    req_ready_next = 1'b0;
                    if (bus.req_addr >= DEPTH_W) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 64'd0;
                    end else if (bus.req_write) begin
                        state_next        = WR;
                        mem_write_en_next = 1'b1;
                        mem_address_next  = bus.req_addr;
                        mem_data_in_next  = bus.req_wdata;
                    end else begin
                        state_next       = RD_WAIT;
                        mem_read_en_next = 1'b1;
                        mem_address_next = bus.req_addr;
                        rd_cnt_next      = 2'd0;
                    end
                end
            end

            RD_WAIT: begin
                if (rd_cnt == LAST_RD) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b0;
                    resp_rdata_next = bus.mem_out;
                end else begin
                    mem_read_en_next = 1'b1;
                    rd_cnt_next      = rd_cnt + 2'd1;
                end
            end

            WR: begin
                state_next      = RESP;
                resp_valid_next = 1'b1;
                resp_err_next   = 1'b0;
                resp_rdata_next = 64'd0;
            end

            RESP: begin
                if (bus.resp_ready) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b0;
                    resp_err_next   = 1'b0;
                    resp_rdata_next = 64'd0;
                    req_ready_next  = 1'b1;
                    txn_count_next  = txn_count_q + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_data_in  = mem_data_in_q;
    assign bus.mem_read_en  = mem_read_en_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign txn_count        = txn_count_q;

endmodule

// File: tb/tb_dmem_master.sv
// Testbench for dmem_master: two instances (READ_LATENCY 1 and 3), each with
// its own behavioural RAM whose word i starts out holding i*100.
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_ready = 1'b0;
    logic [15:0] txn1, txn3;

    int assertions = 0;
    int failures   = 0;
    int expTxn1    = 0;
    int expTxn3    = 0;

    logic [63:0] expAddr = 64'd0;
    logic [63:0] expWdata = 64'd0;

    int rdCycles = 0;
    int wrCycles = 0;
    int addrErr  = 0;
    int bothHigh = 0;

    logic [63:0] ram1 [32];
    logic [63:0] ram3 [32];

    dmem_master_if if1 ();
    dmem_master_if if3 ();

    dmem_master #(.DEPTH(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .txn_count(txn1));

    dmem_master #(.DEPTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.master), .txn_count(txn3));

    always #5 clk = ~clk;

    assign if1.req_valid  = req_valid & ~sel;
    assign if3.req_valid  = req_valid & sel;
    assign if1.req_write  = req_write;
    assign if3.req_write  = req_write;
    assign if1.req_addr   = req_addr;
    assign if3.req_addr   = req_addr;
    assign if1.req_wdata  = req_wdata;
    assign if3.req_wdata  = req_wdata;
    assign if1.resp_ready = resp_ready & ~sel;
    assign if3.resp_ready = resp_ready & sel;

    assign if1.mem_out = (if1.mem_address < 64'd32) ? ram1[if1.mem_address[4:0]] : 64'd0;
    assign if3.mem_out = (if3.mem_address < 64'd32) ? ram3[if3.mem_address[4:0]] : 64'd0;

    // RAM models: preload during reset, take writes otherwise
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ram1[i] <= 64'(i) * 64'd100;
        end else if (if1.mem_write_en && if1.mem_address < 64'd32) begin
            ram1[if1.mem_address[4:0]] <= if1.mem_data_in;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ram3[i] <= 64'(i) * 64'd100;
        end else if (if3.mem_write_en && if3.mem_address < 64'd32) begin
            ram3[if3.mem_address[4:0]] <= if3.mem_data_in;
        end
    end

    logic        cur_req_ready, cur_resp_valid, cur_resp_err, cur_rd_en, cur_wr_en;
    logic [63:0] cur_rdata, cur_mem_address, cur_data_in;
    logic [15:0] cur_txn;

    assign cur_req_ready   = sel ? if3.req_ready    : if1.req_ready;
    assign cur_resp_valid  = sel ? if3.resp_valid   : if1.resp_valid;
    assign cur_resp_err    = sel ? if3.resp_err     : if1.resp_err;
    assign cur_rdata       = sel ? if3.resp_rdata   : if1.resp_rdata;
    assign cur_rd_en       = sel ? if3.mem_read_en  : if1.mem_read_en;
    assign cur_wr_en       = sel ? if3.mem_write_en : if1.mem_write_en;
    assign cur_mem_address = sel ? if3.mem_address  : if1.mem_address;
    assign cur_data_in     = sel ? if3.mem_data_in  : if1.mem_data_in;
    assign cur_txn         = sel ? txn3 : txn1;

    // Cumulative bus monitor: enable cycles, address/data on enables, read/write overlap
    always @(negedge clk) begin
        if (if1.mem_read_en && if1.mem_write_en) bothHigh++;
        if (if3.mem_read_en && if3.mem_write_en) bothHigh++;
        if (cur_rd_en) begin
            rdCycles++;
            if (cur_mem_address !== expAddr) addrErr++;
        end
        if (cur_wr_en) begin
            wrCycles++;
            if (cur_mem_address !== expAddr || cur_data_in !== expWdata) addrErr++;
        end
    end

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expRd;
        int          expWr;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One complete request/response on the selected instance, checking latency, data and bus activity
    task automatic applyStimulus(input vec_t v, input logic useL3, input string tag);
        int lat, rd0, wr0, ae0, expT;
        sel      = useL3;
        expAddr  = v.addr;
        expWdata = v.wdata;
        @(negedge clk);
        checkOutput({tag, ".req_ready"}, 64'(cur_req_ready), 64'd1);
        rd0 = rdCycles; wr0 = wrCycles; ae0 = addrErr;
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!cur_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(v.expLat));
        checkOutput({tag, ".resp_rdata"}, cur_rdata, v.expRdata);
        checkOutput({tag, ".resp_err"}, 64'(cur_resp_err), 64'(v.expErr));
        checkOutput({tag, ".read_cycles"}, 64'(rdCycles - rd0), 64'(v.expRd));
        checkOutput({tag, ".write_cycles"}, 64'(wrCycles - wr0), 64'(v.expWr));
        checkOutput({tag, ".bus_addr_data"}, 64'(addrErr - ae0), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (useL3) begin expTxn3++; expT = expTxn3; end
        else begin expTxn1++; expT = expTxn1; end
        checkOutput({tag, ".resp_valid_after"}, 64'(cur_resp_valid), 64'd0);
        checkOutput({tag, ".req_ready_after"}, 64'(cur_req_ready), 64'd1);
        checkOutput({tag, ".txn_count"}, 64'(cur_txn), 64'(expT));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, wr0, seen;
        vec_t v;

        vecs[0] = '{1'b0, 64'd5,  64'd0,      64'd500,  1'b0, 2, 1, 0};
        vecs[1] = '{1'b1, 64'd3,  64'hABCD,   64'd0,    1'b0, 2, 0, 1};
        vecs[2] = '{1'b0, 64'd3,  64'd0,      64'hABCD, 1'b0, 2, 1, 0};
        vecs[3] = '{1'b0, 64'd32, 64'd0,      64'd0,    1'b1, 1, 0, 0};
        vecs[4] = '{1'b0, 64'd31, 64'd0,      64'd3100, 1'b0, 2, 1, 0};
        vecs[5] = '{1'b1, 64'd40, 64'h1111,   64'd0,    1'b1, 1, 0, 0};
        vecs[6] = '{1'b1, 64'd31, 64'h123456789ABCDEF0, 64'd0, 1'b0, 2, 0, 1};
        vecs[7] = '{1'b0, 64'd31, 64'd0,      64'h123456789ABCDEF0, 1'b0, 2, 1, 0};
        vecs[8] = '{1'b0, 64'd0,  64'd0,      64'd0,    1'b0, 2, 1, 0};
        vecs[9] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1, 0, 0};

        // Reset values while rst_n is held low
        repeat (3) @(negedge clk);
        checkOutput("rst.req_ready",    64'(if1.req_ready), 64'd0);
        checkOutput("rst.resp_valid",   64'(if1.resp_valid), 64'd0);
        checkOutput("rst.resp_err",     64'(if1.resp_err), 64'd0);
        checkOutput("rst.resp_rdata",   if1.resp_rdata, 64'd0);
        checkOutput("rst.mem_read_en",  64'(if1.mem_read_en), 64'd0);
        checkOutput("rst.mem_write_en", 64'(if1.mem_write_en), 64'd0);
        checkOutput("rst.mem_address",  if1.mem_address, 64'd0);
        checkOutput("rst.mem_data_in",  if1.mem_data_in, 64'd0);
        checkOutput("rst.txn_count",    64'(txn1), 64'd0);
        checkOutput("rst.l3_req_ready", 64'(if3.req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst.req_ready_before_edge", 64'(if1.req_ready), 64'd0);
        @(negedge clk);
        checkOutput("rst.req_ready_first_edge", 64'(if1.req_ready), 64'd1);

        // Table-driven transactions on the READ_LATENCY=1 instance
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Response back-pressure: hold resp_ready low, present a second request meanwhile
        sel = 1'b0;
        expAddr = 64'd7;
        expWdata = 64'd0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd7; req_wdata = 64'd0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!if1.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp.latency", 64'(lat), 64'd2);
        wr0 = wrCycles;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp.resp_valid%0d", i), 64'(if1.resp_valid), 64'd1);
            checkOutput($sformatf("bp.resp_rdata%0d", i), if1.resp_rdata, 64'd700);
            checkOutput($sformatf("bp.req_ready%0d", i), 64'(if1.req_ready), 64'd0);
            req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd9; req_wdata = 64'hDEAD;
            @(negedge clk);
        end
        checkOutput("bp.resp_valid_held", 64'(if1.resp_valid), 64'd1);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        expTxn1++;
        checkOutput("bp.txn_count", 64'(txn1), 64'(expTxn1));
        checkOutput("bp.req_ready_after", 64'(if1.req_ready), 64'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (if1.resp_valid) seen++;
        end
        checkOutput("bp.no_queued_resp", 64'(seen), 64'd0);
        checkOutput("bp.no_queued_write", 64'(wrCycles - wr0), 64'd0);
        v = '{1'b0, 64'd9, 64'd0, 64'd900, 1'b0, 2, 1, 0};
        applyStimulus(v, 1'b0, "bp.reload9");

        // READ_LATENCY=3 instance: three read cycles, response at N+4
        v = '{1'b0, 64'd7, 64'd0, 64'd700, 1'b0, 4, 3, 0};
        applyStimulus(v, 1'b1, "l3.load7");

        // Reset pulsed while the READ_LATENCY=3 instance sits in RD_WAIT
        sel = 1'b1;
        expAddr = 64'd2;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd2;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rr.read_en_before", 64'(if3.mem_read_en), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rr.read_en_dropped", 64'(if3.mem_read_en), 64'd0);
        checkOutput("rr.resp_valid", 64'(if3.resp_valid), 64'd0);
        checkOutput("rr.txn_count", 64'(txn3), 64'd0);
        checkOutput("rr.l1_txn_count", 64'(txn1), 64'd0);
        expTxn1 = 0;
        expTxn3 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rr.req_ready_after_release", 64'(if3.req_ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (if3.resp_valid) seen++;
        end
        checkOutput("rr.no_response", 64'(seen), 64'd0);
        checkOutput("rr.txn_still_zero", 64'(txn3), 64'd0);
        applyStimulus(vecs[0], 1'b0, "rr.l1_after");

        checkOutput("bus.read_write_overlap", 64'(bothHigh), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
